// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: rate-codes N_CH intensity levels into spike trains via prescaled phase accumulators.
// Define SPIKE_ENC_STAGGER_EN to start each channel's accumulator at a distinct phase (i*2^LEVEL_W/N_CH).
module spike_rate_encoder #(
  parameter int N_CH       = 8,
  parameter int LEVEL_W    = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [$clog2(N_CH)-1:0]   wr_addr,
  input  logic [LEVEL_W-1:0]        wr_data,
  input  logic [PRESCALE_W-1:0]     prescale,
  output logic [N_CH-1:0]           spike_out,
  output logic                      tick_out
);
  localparam int AW = $clog2(N_CH);
  logic [PRESCALE_W-1:0] pc;
  logic [N_CH-1:0]       carry;
  logic                  tick;
  assign tick = ena && !clear && (pc == prescale);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
`ifdef SPIKE_ENC_STAGGER_EN
    localparam logic [LEVEL_W-1:0] INIT = LEVEL_W'(i * (2 ** LEVEL_W) / N_CH);
`else
    localparam logic [LEVEL_W-1:0] INIT = '0;
`endif
    logic [LEVEL_W-1:0] shadow;
    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] acc;
    logic [LEVEL_W:0]   sum;
    assign sum      = {1'b0, acc} + {1'b0, level};
    assign carry[i] = sum[LEVEL_W];
    // level only moves at a tick, so a write never disturbs the rate mid-period
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        shadow <= '0;
        level  <= '0;
        acc    <= INIT;
      end else begin
        if (wr_en && wr_addr == AW'(i)) shadow <= wr_data;
        if (clear) acc <= INIT;
        else if (tick) begin
          acc   <= sum[LEVEL_W-1:0];
          level <= shadow;
        end
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc        <= '0;
      spike_out <= '0;
      tick_out  <= 1'b0;
    end else begin
      pc        <= (clear || tick) ? '0 : ena ? pc + 1'b1 : pc;
      spike_out <= tick ? carry : '0;
      tick_out  <= tick;
    end
endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb_spike_rate_encoder: directed checks of rate, prescaler, commit timing, clear/ena/reset and stagger.
module tb_spike_rate_encoder;
  logic       clk = 1'b0;
  logic       rst_n, ena, clear, wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data, prescale;
  logic [7:0] spike_out;
  logic       tick_out;
  int n_cmp = 0;
  int n_err = 0;

  spike_rate_encoder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .prescale(prescale),
    .spike_out(spike_out), .tick_out(tick_out)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int c2, c3, n;
    logic [7:0] exp8;
    rst_n = 0; ena = 0; clear = 0; wr_en = 0; wr_addr = 0; wr_data = 0; prescale = 0;
    repeat (2) cyc();
    chk("reset_spike", spike_out, 0);
    chk("reset_tick", tick_out, 0);
    rst_n = 1;
    // basic rate: ch0=128, tick every cycle
    wr_en = 1; wr_addr = 0; wr_data = 128;
    cyc();
    chk("idle_tick", tick_out, 0);
    wr_en = 0; ena = 1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("basic_tick", tick_out, 1);
      chk("basic_spike0", spike_out[0], (k >= 3 && k % 2 == 1) ? 1 : 0);
    end
    // prescaler: period 4, ch1=64
    clear = 1; wr_en = 1; wr_addr = 1; wr_data = 64; prescale = 3;
    cyc();
    chk("clear_spike", spike_out, 0);
    chk("clear_tick", tick_out, 0);
    clear = 0; wr_en = 0;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      chk("pre_tick", tick_out, (c % 4 == 0) ? 1 : 0);
      chk("pre_spike1", spike_out[1], (c % 4 == 0 && c / 4 >= 5 && (c / 4 - 5) % 4 == 0) ? 1 : 0);
      chk("pre_spike0", spike_out[0], (c % 4 == 0 && (c / 4) % 2 == 0) ? 1 : 0);
    end
    // rate extremes: ch2=255, ch3=0
    clear = 1; wr_en = 1; wr_addr = 2; wr_data = 255; prescale = 0;
    cyc();
    clear = 0; wr_addr = 3; wr_data = 0;
    cyc();
    chk("ext_commit_tick", tick_out, 1);
    wr_en = 0; c2 = 0; c3 = 0;
    for (int k = 0; k < 512; k++) begin
      cyc();
      c2 += int'(spike_out[2]);
      c3 += int'(spike_out[3]);
    end
    chk("ext_cnt255", c2, 510);
    chk("ext_cnt0", c3, 0);
    // write coincident with tick
    clear = 1; wr_en = 1; wr_addr = 0; wr_data = 0; prescale = 3;
    cyc();
    clear = 0; wr_en = 0;
    repeat (4) cyc();
    chk("coin_commit0_tick", tick_out, 1);
    clear = 1;
    cyc();
    clear = 0;
    repeat (3) cyc();
    wr_en = 1; wr_addr = 0; wr_data = 128;
    cyc();
    chk("coin_t1_tick", tick_out, 1);
    chk("coin_t1", spike_out[0], 0);
    wr_en = 0;
    repeat (4) cyc();
    chk("coin_t2", spike_out[0], 0);
    repeat (4) cyc();
    chk("coin_t3", spike_out[0], 0);
    repeat (4) cyc();
    chk("coin_t4_tick", tick_out, 1);
    chk("coin_t4", spike_out[0], 1);
    // clear mid-run, level retained
    prescale = 0;
    cyc();
    chk("clr_a", spike_out[0], 0);
    cyc();
    chk("clr_b", spike_out[0], 1);
    cyc();
    chk("clr_c", spike_out[0], 0);
    clear = 1;
    cyc();
    chk("clr_spike", spike_out, 0);
    chk("clr_tick", tick_out, 0);
    clear = 0;
    cyc();
    chk("clr_phase0", spike_out[0], 0);
    chk("clr_phase0_tick", tick_out, 1);
    cyc();
    chk("clr_phase1", spike_out[0], 1);
    // ena low holds pc
    clear = 1; prescale = 3;
    cyc();
    clear = 0;
    repeat (2) cyc();
    ena = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("ena0_spike", spike_out, 0);
      chk("ena0_tick", tick_out, 0);
    end
    ena = 1;
    cyc();
    chk("ena_resume_a", tick_out, 0);
    cyc();
    chk("ena_resume_b", tick_out, 1);
    // pc above prescale wraps through 255
    prescale = 7;
    repeat (6) cyc();
    prescale = 2; n = 0;
    do begin
      cyc();
      n++;
    end while (!tick_out && n < 300);
    chk("wrap_cycles", n, 253);
    // async reset between edges
    #3; rst_n = 0; #1;
    chk("async_tick", tick_out, 0);
    chk("async_spike", spike_out, 0);
    cyc();
    rst_n = 1; ena = 0; prescale = 0;
    // stagger: all channels 32
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = 32;
      cyc();
      chk("stg_idle", spike_out, 0);
    end
    wr_en = 0; ena = 1;
    cyc();
    chk("stg_commit", spike_out, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
`ifdef SPIKE_ENC_STAGGER_EN
      exp8 = 8'(1 << (8 - k));
`else
      exp8 = (k == 8) ? 8'hFF : 8'h00;
`endif
      chk("stagger", spike_out, exp8);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
